// File: rtl/vad_decision_tx.sv
// Hangover smoothing of per-frame speech/non-speech classes, frame tagging,
// and a 2-entry valid/ready output buffer toward the host link.
module vad_decision_tx #(
  parameter int HANG_FRAMES = 4,
  parameter int FRM_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [1:0]       res_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_speech,
  output logic [FRM_W-1:0] out_frame,
  output logic             overflow,
  output logic             code_err
);

  typedef enum logic [1:0] {
    SILENCE = 2'd0,
    SPEECH  = 2'd1,
    HANG    = 2'd2
  } state_t;

  localparam logic [3:0] HANG_INIT = (HANG_FRAMES > 0) ? 4'(HANG_FRAMES - 1) : 4'd0;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             ent_sp_q [2];
  logic             ent_sp_d [2];
  logic [FRM_W-1:0] ent_fr_q [2];
  logic [FRM_W-1:0] ent_fr_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             code_err_q, code_err_d;

  logic accept;
  logic is_speech;
  logic decision;
  logic pop;
  logic full;
  logic push_ok;

  assign is_speech = (res_code == 2'b10);
  assign accept    = res_valid && (res_code == 2'b10 || res_code == 2'b01);

  // Hangover FSM: decides the smoothed class of the frame being accepted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    decision = 1'b0;
    if (accept) begin
      unique case (state_q)
        SILENCE: begin
          if (is_speech) begin
            state_d  = SPEECH;
            decision = 1'b1;
          end
        end
        SPEECH: begin
          decision = 1'b1;
          if (!is_speech) begin
            if (HANG_FRAMES == 0) begin
              state_d  = SILENCE;
              decision = 1'b0;
            end else begin
              state_d = HANG;
              cnt_d   = HANG_INIT;
            end
          end
        end
        HANG: begin
          decision = 1'b1;
          if (is_speech) begin
            state_d = SPEECH;
          end else if (cnt_q == 4'd0) begin
            state_d  = SILENCE;
            decision = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = SILENCE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full buffer still takes the push.
  assign out_valid = (level_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign full      = (level_q == 2'd2);
  assign push_ok   = accept && (!full || pop);

  always_comb begin
    frm_d      = frm_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    ent_sp_d   = ent_sp_q;
    ent_fr_d   = ent_fr_q;
    overflow_d = overflow_q;
    code_err_d = code_err_q;
    if (accept) begin
      frm_d = frm_q + FRM_W'(1);
    end
    if (res_valid && res_code == 2'b11) begin
      code_err_d = 1'b1;
    end
    if (accept && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (push_ok) begin
      ent_sp_d[wr_ptr_q] = decision;
      ent_fr_d[wr_ptr_q] = frm_q;
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SILENCE;
      cnt_q      <= 4'd0;
      frm_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      level_q    <= 2'd0;
      overflow_q <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frm_q      <= frm_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      code_err_q <= code_err_d;
    end
  end

  // Entry storage needs no reset: it is only visible while out_valid is high.
  always_ff @(posedge clk) begin
    ent_sp_q <= ent_sp_d;
    ent_fr_q <= ent_fr_d;
  end

  assign out_speech = out_valid & ent_sp_q[rd_ptr_q];
  assign out_frame  = out_valid ? ent_fr_q[rd_ptr_q] : '0;
  assign overflow   = overflow_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_vad_decision_tx.sv
// Bench for vad_decision_tx: two builds (hangover 4 and 0) share stimulus and
// are compared every cycle against a run-length hangover model and a small FIFO model.
module tb_vad_decision_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       res_valid;
  logic [1:0] res_code;
  logic       out_ready;

  logic       a_valid, a_speech, a_ovf, a_cerr;
  logic [7:0] a_frame;
  logic       b_valid, b_speech, b_ovf, b_cerr;
  logic [7:0] b_frame;

  always #5 clk = ~clk;

  vad_decision_tx #(.HANG_FRAMES(4), .FRM_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_code(res_code),
    .out_valid(a_valid), .out_ready(out_ready), .out_speech(a_speech),
    .out_frame(a_frame), .overflow(a_ovf), .code_err(a_cerr)
  );

  vad_decision_tx #(.HANG_FRAMES(0), .FRM_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_code(res_code),
    .out_valid(b_valid), .out_ready(out_ready), .out_speech(b_speech),
    .out_frame(b_frame), .overflow(b_ovf), .code_err(b_cerr)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a decision is speech if the frame is speech, or if
  // speech has been seen and the current non-speech run is within the hangover.
  int         hang_v [2] = '{4, 0};
  bit         seen_sp [2];
  int         ns_run [2];
  logic [7:0] m_frm;
  logic [7:0] fr_buf [2];
  logic       sp_buf [2][2];
  int         m_cnt;
  logic       m_ovf, m_cerr;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        seen_sp[i] = 1'b0;
        ns_run[i]  = 0;
      end
      m_frm  = 8'd0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_cerr = 1'b0;
    end else begin
      if (m_cnt > 0 && out_ready) begin
        fr_buf[0] = fr_buf[1];
        for (int i = 0; i < 2; i++) sp_buf[i][0] = sp_buf[i][1];
        m_cnt--;
      end
      if (res_valid && res_code == 2'b11) m_cerr = 1'b1;
      if (res_valid && (res_code == 2'b10 || res_code == 2'b01)) begin
        logic dec [2];
        for (int i = 0; i < 2; i++) begin
          if (res_code == 2'b10) begin
            seen_sp[i] = 1'b1;
            ns_run[i]  = 0;
            dec[i]     = 1'b1;
          end else begin
            if (seen_sp[i] && ns_run[i] < 100) ns_run[i]++;
            dec[i] = seen_sp[i] && (ns_run[i] <= hang_v[i]);
          end
        end
        if (m_cnt < 2) begin
          fr_buf[m_cnt] = m_frm;
          for (int i = 0; i < 2; i++) sp_buf[i][m_cnt] = dec[i];
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
        m_frm = m_frm + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_a", a_valid, m_cnt > 0);
      check("valid_b", b_valid, m_cnt > 0);
      if (m_cnt > 0) begin
        check("speech_a", a_speech, sp_buf[0][0]);
        check("speech_b", b_speech, sp_buf[1][0]);
        check("frame_a", a_frame, fr_buf[0]);
        check("frame_b", b_frame, fr_buf[0]);
      end
      check("overflow_a", a_ovf, m_ovf);
      check("overflow_b", b_ovf, m_ovf);
      check("code_err_a", a_cerr, m_cerr);
      check("code_err_b", b_cerr, m_cerr);
    end
  end

  // Called at a falling edge: drive inputs, return at the next falling edge.
  task automatic cyc(input logic v, input logic [1:0] c, input logic r);
    res_valid = v;
    res_code  = c;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int codes [7] = '{2, 1, 1, 1, 1, 1, 1};
    int exp_a [7] = '{1, 1, 1, 1, 1, 0, 0};
    int codes2 [5] = '{2, 1, 1, 2, 1};
    logic v;
    logic [1:0] c;
    logic r;

    rst_n = 1'b0; res_valid = 1'b0; res_code = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    cyc(1'b0, 2'b00, 1'b0);
    do_reset();
    check("rst_valid", a_valid, 0);
    check("rst_speech", a_speech, 0);
    check("rst_frame", a_frame, 0);
    check("rst_overflow", a_ovf, 0);
    check("rst_code_err", a_cerr, 0);
    chk_en = 1'b1;

    // Three speech frames streamed with ready high.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'b10, 1'b1);
      check("stream_valid", a_valid, 1);
      check("stream_speech", a_speech, 1);
      check("stream_frame", a_frame, i);
    end
    cyc(1'b0, 2'b00, 1'b1);

    // Hangover sequences.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 2'(codes[i]), 1'b1);
      check("hang4_speech", a_speech, exp_a[i]);
      if (i < 2) check("hang0_speech", b_speech, (i == 0) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'(codes2[i]), 1'b1);
      check("reentry_speech", a_speech, 1);
    end
    cyc(1'b0, 2'b00, 1'b1);

    // Overflow with ready held low.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 1'b0);
    check("ovf_flag", a_ovf, 1);
    check("ovf_head0", a_frame, 0);
    cyc(1'b0, 2'b00, 1'b1);
    check("ovf_head1", a_frame, 1);
    cyc(1'b0, 2'b00, 1'b1);
    check("ovf_empty", a_valid, 0);
    cyc(1'b1, 2'b01, 1'b1);
    check("ovf_next_idx", a_frame, 3);

    // Full buffer with simultaneous push and pop.
    do_reset();
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b10, 1'b1);
    check("pp_no_ovf", a_ovf, 0);
    check("pp_head1", a_frame, 1);
    cyc(1'b0, 2'b00, 1'b1);
    check("pp_head2", a_frame, 2);
    cyc(1'b0, 2'b00, 1'b1);

    // Ignored codes, then index wrap.
    do_reset();
    cyc(1'b1, 2'b00, 1'b1);
    cyc(1'b1, 2'b11, 1'b1);
    check("code_no_out", a_valid, 0);
    check("code_err_set", a_cerr, 1);
    cyc(1'b1, 2'b01, 1'b1);
    check("code_first_idx", a_frame, 0);
    for (int i = 0; i < 255; i++) cyc(1'b1, 2'b10, 1'b1);
    check("wrap_255", a_frame, 255);
    cyc(1'b1, 2'b01, 1'b1);
    check("wrap_0", a_frame, 0);

    // Reset in the middle of a hangover.
    cyc(1'b1, 2'b10, 1'b1);
    cyc(1'b1, 2'b01, 1'b1);
    rst_n = 1'b0;
    cyc(1'b1, 2'b10, 1'b1);
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_frame", a_frame, 0);
    check("mid_rst_code_err", a_cerr, 0);
    rst_n = 1'b1;
    cyc(1'b1, 2'b01, 1'b1);
    check("mid_rst_speech", a_speech, 0);
    check("mid_rst_idx", a_frame, 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 4) c = 2'b10;
      else if ($urandom_range(0, 9) < 8) c = 2'b01;
      else c = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(v, c, r);
    end
    rst_n = 1'b1;
    cyc(1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
